wave_synth_param: RTL and testbench
===================================

Name: wave_synth_param

Overview:
Parametrised successor to the fixed 5-bit triangle signal generator. Produces a registered digital waveform: triangle, rising sawtooth, falling sawtooth or square. Peak and step are programmable at run time, and there is a clock-enable. Sits in the signal-generation path feeding DAC/test-pattern logic. With WIDTH=5, mode=TRI, step=1, peak=31 and en=1 it reproduces the legacy 0..31..0 triangle sequence exactly.

Parameters:
WIDTH, 5, output/accumulator width in bits
STEP_W, 4, width of the step input

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  advance enable; low = hold all state
mode  input  2  0=TRI, 1=SAW_UP, 2=SAW_DN, 3=SQUARE
step  input  STEP_W  increment per enabled cycle; 0 treated as 1
peak  input  WIDTH  upper level (inclusive)
wave  output  WIDTH  registered waveform sample
dir  output  1  1=rising phase, 0=falling phase
wrap  output  1  one-cycle pulse at period start

Behaviour:
- Reset (async, rst_n=0): acc=0, wave=0, dir=1, wrap=0, mode_q=TRI. Outputs change immediately on reset assertion, mid-run included.
- All outputs are registered. Arithmetic is done at WIDTH+1 bits, so no intermediate overflow occurs. The effective step s is step, or 1 when step=0.
- en=0: acc, dir, wave and mode_q hold; wrap=0.
- Mode change (en=1 and mode!=mode_q) takes effect on one clock edge:
  - mode_q<=mode, acc<=0, dir<=1, wave<=0, wrap<=1.
  - No waveform step is taken that cycle.
- TRI, two states UP/DOWN held in dir:
  - UP: if acc+s>=peak, then acc<=peak and dir<=0; else acc<=acc+s.
  - DOWN: if acc<=s, then acc<=0, dir<=1, wrap<=1; else acc<=acc-s.
  - wave<=next acc.
- SAW_UP: if acc+s>peak, then acc<=0 and wrap<=1; else acc<=acc+s. dir stays 1. wave<=next acc.
- SAW_DN: if acc<s, then acc<=peak and wrap<=1; else acc<=acc-s. dir stays 0. wave<=next acc.
  - From reset (acc=0) the first enabled cycle jumps to peak.
- SQUARE: acc and dir follow the TRI rules exactly, including wrap. wave<=peak when next dir=0, else 0.
- peak=0: TRI/SAW_UP/SAW_DN/SQUARE all yield wave=0.
  - TRI, SAW_UP and SAW_DN assert wrap on every enabled cycle.
  - SQUARE: dir toggles every enabled cycle; wrap is asserted on every second enabled cycle (each DOWN->UP return).
- Peak lowered below acc mid-run:
  - TRI: immediately clamps to peak and turns down.
  - SAW_UP: wraps to 0.
  - SAW_DN: continues decrementing.
  - No illegal state is reachable.
- wrap is 0 in every cycle not listed above.

Decomposition:
- Package wave_synth_pkg holds the mode localparams (MODE_TRI=2'd0, MODE_SAW_UP=2'd1, MODE_SAW_DN=2'd2, MODE_SQUARE=2'd3) and DIR_UP=1'b1/DIR_DN=1'b0.
- Sub-module wave_synth_next: purely combinational next-state computation (acc, dir, wrap from acc, dir, mode, s, peak). It is instantiated once; the top holds registers, enable and mode-change logic.

Test Plan:
1. Legacy check: WIDTH=5, mode=0, step=1, peak=31, en=1, release reset.
   -> wave 0,1,...,31,30,...,1,0,1... (period 62 cycles); wrap high on each return to 0.
2. TRI, step=3, peak=20.
   -> wave 0,3,6,9,12,15,18,20,17,14,11,8,5,2,0; dir falls at 20; wrap on the 0.
3. SAW_UP, step=4, peak=15.
   -> 0,4,8,12,0,4... with wrap on each 0 after the first. SAW_DN, step=3, peak=10, from reset -> 10,7,4,1,10,7...; wrap on each 10.
4. SQUARE, step=1, peak=3.
   -> wave 0,0,3,3,3,0,0,0,3... (3 high / 3 low after the first low phase); wrap at each high->low acc return.
5. TRI running at wave=12 rising: drop en for 5 cycles.
   -> wave holds 12, wrap=0. Raise en -> 13. Then switch mode to 1 -> next cycle wave=0, wrap=1, then 1,2...
6. Assert rst_n=0 asynchronously mid-cycle at wave=25.
   -> wave=0, dir=1, wrap=0 before the next edge. Set step=0 after release -> behaves as step=1.

Source files
------------

// File: rtl/wave_synth_pkg.sv
// Shared mode and direction encodings for the parametrised waveform synthesiser.
package wave_synth_pkg;
  localparam logic [1:0] MODE_TRI    = 2'd0;
  localparam logic [1:0] MODE_SAW_UP = 2'd1;
  localparam logic [1:0] MODE_SAW_DN = 2'd2;
  localparam logic [1:0] MODE_SQUARE = 2'd3;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
endpackage

// File: rtl/wave_synth_next.sv
// Combinational next-state for the waveform accumulator: new acc, direction and period-start flag.
// Combinational only; the caller owns registers, enable and mode-change handling.
module wave_synth_next
  import wave_synth_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  acc_i,
  input  logic              dir_i,
  input  logic [1:0]        mode_i,
  input  logic [STEP_W-1:0] s_i,
  input  logic [WIDTH-1:0]  peak_i,
  output logic [WIDTH-1:0]  acc_o,
  output logic              dir_o,
  output logic              wrap_o
);
  // One guard bit above the wider operand so acc+s never overflows.
  localparam int AW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

  logic [AW-1:0] acc_x, s_x, pk_x, sum_x, dif_x;

  assign acc_x = AW'(acc_i);
  assign s_x   = AW'(s_i);
  assign pk_x  = AW'(peak_i);
  assign sum_x = acc_x + s_x;
  assign dif_x = acc_x - s_x;

  always_comb begin
    acc_o  = acc_i;
    dir_o  = dir_i;
    wrap_o = 1'b0;
    case (mode_i)
      MODE_SAW_UP: begin
        dir_o = DIR_UP;
        if (sum_x > pk_x) begin
          acc_o  = '0;
          wrap_o = 1'b1;
        end else begin
          acc_o = WIDTH'(sum_x);
        end
      end
      MODE_SAW_DN: begin
        dir_o = DIR_DN;
        if (acc_x < s_x) begin
          acc_o  = peak_i;
          wrap_o = 1'b1;
        end else begin
          acc_o = WIDTH'(dif_x);
        end
      end
      default: begin
        // A zero-height triangle is a one-cycle period; square keeps toggling dir.
        if (mode_i == MODE_TRI && peak_i == '0) begin
          acc_o  = '0;
          dir_o  = DIR_UP;
          wrap_o = 1'b1;
        end else if (dir_i == DIR_UP) begin
          if (sum_x >= pk_x) begin
            acc_o = peak_i;
            dir_o = DIR_DN;
          end else begin
            acc_o = WIDTH'(sum_x);
          end
        end else begin
          if (acc_x <= s_x) begin
            acc_o  = '0;
            dir_o  = DIR_UP;
            wrap_o = 1'b1;
          end else begin
            acc_o = WIDTH'(dif_x);
          end
        end
      end
    endcase
  end
endmodule

// File: rtl/wave_synth_param.sv
// Registered triangle / sawtooth / square generator with run-time peak, step and clock-enable.
// One cycle from enable to new sample; en low freezes all state.
module wave_synth_param
  import wave_synth_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  peak,
  output logic [WIDTH-1:0]  wave,
  output logic              dir,
  output logic              wrap
);
  logic [WIDTH-1:0]  acc_q, acc_d, acc_n, wave_q, wave_d;
  logic              dir_q, dir_d, dir_n, wrap_q, wrap_d, wrap_n;
  logic [1:0]        mode_q, mode_d;
  logic [STEP_W-1:0] s_w;

  assign s_w = (step == '0) ? STEP_W'(1) : step;

  wave_synth_next #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_next (
    .acc_i  (acc_q),
    .dir_i  (dir_q),
    .mode_i (mode_q),
    .s_i    (s_w),
    .peak_i (peak),
    .acc_o  (acc_n),
    .dir_o  (dir_n),
    .wrap_o (wrap_n)
  );

  always_comb begin
    acc_d  = acc_q;
    dir_d  = dir_q;
    wave_d = wave_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    if (en) begin
      // A mode switch restarts the period and skips the waveform step.
      if (mode != mode_q) begin
        mode_d = mode;
        acc_d  = '0;
        dir_d  = DIR_UP;
        wave_d = '0;
        wrap_d = 1'b1;
      end else begin
        acc_d  = acc_n;
        dir_d  = dir_n;
        wrap_d = wrap_n;
        if (mode_q == MODE_SQUARE) begin
          wave_d = (dir_n == DIR_DN) ? peak : '0;
        end else begin
          wave_d = acc_n;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      wave_q <= '0;
      dir_q  <= DIR_UP;
      wrap_q <= 1'b0;
      mode_q <= MODE_TRI;
    end else begin
      acc_q  <= acc_d;
      wave_q <= wave_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
      mode_q <= mode_d;
    end
  end

  assign wave = wave_q;
  assign dir  = dir_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_wave_synth_param.sv
// Directed bench for wave_synth_param with hand-derived sample tables.
module tb_wave_synth_param;
  logic       clk, rst_n, en;
  logic [1:0] mode;
  logic [3:0] step;
  logic [4:0] peak;
  logic [4:0] wave;
  logic       dir, wrap;

  int tests, fails;
  int ew;

  int t2_w[14]  = '{3, 6, 9, 12, 15, 18, 20, 17, 14, 11, 8, 5, 2, 0};
  int su_w[8]   = '{4, 8, 12, 0, 4, 8, 12, 0};
  int sd_w[6]   = '{10, 7, 4, 1, 10, 7};
  int sq_w[9]   = '{0, 0, 3, 3, 3, 0, 0, 0, 3};
  int sq_wr[9]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
  int sq_d[9]   = '{1, 1, 0, 0, 0, 1, 1, 1, 0};

  wave_synth_param #(.WIDTH(5), .STEP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .step  (step),
    .peak  (peak),
    .wave  (wave),
    .dir   (dir),
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 2'd0;
    step  = 4'd1;
    peak  = 5'd31;
    #12;
    check("reset_wave", 32'(wave), 0);
    check("reset_dir",  32'(dir),  1);
    check("reset_wrap", 32'(wrap), 0);
    rst_n = 1'b1;

    // Legacy triangle 0..31..0
    en = 1'b1;
    for (int i = 1; i <= 63; i++) begin
      tick();
      ew = (i <= 31) ? i : ((i <= 62) ? 62 - i : i - 62);
      check($sformatf("legacy_wave[%0d]", i), 32'(wave), 32'(ew));
      check($sformatf("legacy_wrap[%0d]", i), 32'(wrap), 32'(i == 62));
      check($sformatf("legacy_dir[%0d]", i),  32'(dir),  32'((i < 31) || (i >= 62)));
    end

    // TRI step 3 peak 20
    do_reset();
    mode = 2'd0; step = 4'd3; peak = 5'd20; en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      check($sformatf("tri3_wave[%0d]", i), 32'(wave), 32'(t2_w[i]));
      check($sformatf("tri3_wrap[%0d]", i), 32'(wrap), 32'(i == 13));
      check($sformatf("tri3_dir[%0d]", i),  32'(dir),  32'(!(i >= 6 && i < 13)));
    end

    // SAW_UP step 4 peak 15
    do_reset();
    mode = 2'd1; step = 4'd4; peak = 5'd15; en = 1'b1;
    tick();
    check("sawup_chg_wave", 32'(wave), 0);
    check("sawup_chg_wrap", 32'(wrap), 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("sawup_wave[%0d]", i), 32'(wave), 32'(su_w[i]));
      check($sformatf("sawup_wrap[%0d]", i), 32'(wrap), 32'(i == 3 || i == 7));
      check($sformatf("sawup_dir[%0d]", i),  32'(dir),  1);
    end

    // SAW_DN step 3 peak 10
    do_reset();
    mode = 2'd2; step = 4'd3; peak = 5'd10; en = 1'b1;
    tick();
    check("sawdn_chg_wave", 32'(wave), 0);
    check("sawdn_chg_wrap", 32'(wrap), 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("sawdn_wave[%0d]", i), 32'(wave), 32'(sd_w[i]));
      check($sformatf("sawdn_wrap[%0d]", i), 32'(wrap), 32'(i == 0 || i == 4));
      check($sformatf("sawdn_dir[%0d]", i),  32'(dir),  0);
    end

    // SQUARE step 1 peak 3
    do_reset();
    mode = 2'd3; step = 4'd1; peak = 5'd3; en = 1'b1;
    tick();
    check("sq_chg_wrap", 32'(wrap), 1);
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("sq_wave[%0d]", i), 32'(wave), 32'(sq_w[i]));
      check($sformatf("sq_wrap[%0d]", i), 32'(wrap), 32'(sq_wr[i]));
      check($sformatf("sq_dir[%0d]", i),  32'(dir),  32'(sq_d[i]));
    end

    // peak = 0 corner cases
    do_reset();
    mode = 2'd0; step = 4'd1; peak = 5'd0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("tri_p0_wave[%0d]", i), 32'(wave), 0);
      check($sformatf("tri_p0_wrap[%0d]", i), 32'(wrap), 1);
    end
    mode = 2'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("saw_p0_wave[%0d]", i), 32'(wave), 0);
      check($sformatf("saw_p0_wrap[%0d]", i), 32'(wrap), 1);
    end
    mode = 2'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("sawdn_p0_wave[%0d]", i), 32'(wave), 0);
      check($sformatf("sawdn_p0_wrap[%0d]", i), 32'(wrap), 1);
    end
    mode = 2'd3;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("sq_p0_wave[%0d]", i), 32'(wave), 0);
      check($sformatf("sq_p0_dir[%0d]", i),  32'(dir),  32'(i % 2));
      check($sformatf("sq_p0_wrap[%0d]", i), 32'(wrap), 32'(i % 2));
    end

    // Peak lowered below acc mid-run
    do_reset();
    mode = 2'd0; step = 4'd1; peak = 5'd31; en = 1'b1;
    repeat (10) tick();
    check("lower_tri_pre", 32'(wave), 10);
    peak = 5'd5;
    tick();
    check("lower_tri_clamp", 32'(wave), 5);
    check("lower_tri_dir",   32'(dir),  0);
    tick();
    check("lower_tri_down",  32'(wave), 4);
    do_reset();
    mode = 2'd1; step = 4'd1; peak = 5'd31; en = 1'b1;
    repeat (11) tick();
    check("lower_saw_pre", 32'(wave), 10);
    peak = 5'd5;
    tick();
    check("lower_saw_wave", 32'(wave), 0);
    check("lower_saw_wrap", 32'(wrap), 1);

    // Enable hold, then mode switch
    do_reset();
    mode = 2'd0; step = 4'd1; peak = 5'd31; en = 1'b1;
    repeat (12) tick();
    check("hold_pre", 32'(wave), 12);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold_wave[%0d]", i), 32'(wave), 12);
      check($sformatf("hold_wrap[%0d]", i), 32'(wrap), 0);
    end
    en = 1'b1;
    tick();
    check("hold_resume", 32'(wave), 13);
    mode = 2'd1;
    tick();
    check("switch_wave", 32'(wave), 0);
    check("switch_wrap", 32'(wrap), 1);
    tick();
    check("switch_next1", 32'(wave), 1);
    check("switch_next1_wrap", 32'(wrap), 0);
    tick();
    check("switch_next2", 32'(wave), 2);

    // Asynchronous reset mid-cycle, then step = 0 acts as 1
    do_reset();
    mode = 2'd0; step = 4'd1; peak = 5'd31; en = 1'b1;
    repeat (25) tick();
    check("arst_pre", 32'(wave), 25);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_wave", 32'(wave), 0);
    check("arst_dir",  32'(dir),  1);
    check("arst_wrap", 32'(wrap), 0);
    tick();
    rst_n = 1'b1;
    step  = 4'd0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("step0_wave[%0d]", i), 32'(wave), 32'(i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
